// File: rtl/lcd_bus_receiver.sv
// Receiving end of an HD44780-style 8-bit LCD bus: tracks AC, busy time and logs writes into an event FIFO.
// Optional bus readback of status/data is enabled with LCD_RX_READBACK_EN.
module lcd_bus_receiver #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned BUSY_CYCLES     = 1850,
  parameter int unsigned CLR_BUSY_CYCLES = 76000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_rs,
  output logic [7:0] evt_data,
  output logic [6:0] evt_addr,
  output logic [6:0] ac,
  output logic       busy,
  output logic [1:0] err,
  input  logic       err_clr
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EVT_W    = 16;
  localparam int unsigned BUSY_MAX = (CLR_BUSY_CYCLES > BUSY_CYCLES) ? CLR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int unsigned BUSY_W   = $clog2(BUSY_MAX + 1);

  // Bus input synchronizers; all four signals share the same depth so they stay aligned.
  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic [7:0]             db_sync [SYNC_STAGES];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en_sync <= '0;
      rs_sync <= '0;
      rw_sync <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) db_sync[i] <= '0;
    end else begin
      en_sync    <= {en_sync[SYNC_STAGES-2:0], lcd_en};
      rs_sync    <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
      rw_sync    <= {rw_sync[SYNC_STAGES-2:0], lcd_rw};
      db_sync[0] <= lcd_data_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) db_sync[i] <= db_sync[i-1];
    end
  end

  logic       e_s, rs_s, rw_s;
  logic [7:0] db_s;
  logic       e_prev;
  logic       fall;

  assign e_s  = en_sync[SYNC_STAGES-1];
  assign rs_s = rs_sync[SYNC_STAGES-1];
  assign rw_s = rw_sync[SYNC_STAGES-1];
  assign db_s = db_sync[SYNC_STAGES-1];
  assign fall = e_prev & ~e_s;

  // Capture the transaction on the falling edge; it is acted on one cycle later.
  logic       pend_valid, pend_rs, pend_rw;
  logic [7:0] pend_db;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      e_prev     <= 1'b0;
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_rw    <= 1'b0;
      pend_db    <= '0;
    end else begin
      e_prev     <= e_s;
      pend_valid <= fall;
      pend_rs    <= rs_s;
      pend_rw    <= rw_s;
      pend_db    <= db_s;
    end
  end

  logic              is_wr, long_busy;
  logic [6:0]        ac_n;
  logic              id_q, id_n;
  logic [BUSY_W-1:0] busy_cnt, busy_cnt_n;
  logic [1:0]        err_n;

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic             pop, push_ok, full;
  logic [EVT_W-1:0] entry, head_n;

  assign is_wr = pend_valid & ~pend_rw;
  assign entry = {pend_rs, pend_db, ac};

  // Instruction decode, AC/id, busy timer, error flags.
  always_comb begin
    ac_n      = ac;
    id_n      = id_q;
    long_busy = 1'b0;
    if (is_wr) begin
      if (pend_rs) begin
        ac_n = id_q ? ac + 7'd1 : ac - 7'd1;
      end else if (pend_db[7]) begin
        ac_n = pend_db[6:0];
      end else if (pend_db[6:3] != 4'd0) begin
        ac_n = ac;
      end else if (pend_db[2]) begin
        id_n = pend_db[1];
      end else if (pend_db[1]) begin
        ac_n      = 7'd0;
        long_busy = 1'b1;
      end else if (pend_db[0]) begin
        ac_n      = 7'd0;
        id_n      = 1'b1;
        long_busy = 1'b1;
      end
    end
`ifdef LCD_RX_READBACK_EN
    if (pend_valid && pend_rw && pend_rs) ac_n = id_q ? ac + 7'd1 : ac - 7'd1;
`endif

    if (is_wr)              busy_cnt_n = long_busy ? BUSY_W'(CLR_BUSY_CYCLES) : BUSY_W'(BUSY_CYCLES);
    else if (busy_cnt != 0) busy_cnt_n = busy_cnt - BUSY_W'(1);
    else                    busy_cnt_n = busy_cnt;

    err_n = err_clr ? 2'b00 : err;
    if (is_wr && busy)                err_n[1] = 1'b1;
    if (is_wr && !push_ok)            err_n[0] = 1'b1;
  end

  // Event FIFO pointer arithmetic; the head is pre-computed so evt_* are registered.
  always_comb begin
    pop      = evt_valid & evt_ready;
    full     = (count == CNT_W'(FIFO_DEPTH));
    push_ok  = is_wr & (~full | pop);
    wr_ptr_n = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n  = count + CNT_W'(push_ok) - CNT_W'(pop);
    if (count_n == '0)                          head_n = {evt_rs, evt_data, evt_addr};
    else if (push_ok && (wr_ptr == rd_ptr_n))   head_n = entry;
    else                                        head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ac        <= '0;
      id_q      <= 1'b1;
      busy_cnt  <= '0;
      busy      <= 1'b0;
      err       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_rs    <= 1'b0;
      evt_data  <= '0;
      evt_addr  <= '0;
    end else begin
      ac        <= ac_n;
      id_q      <= id_n;
      busy_cnt  <= busy_cnt_n;
      busy      <= (busy_cnt_n != '0);
      err       <= err_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      {evt_rs, evt_data, evt_addr} <= head_n;
    end
  end

`ifdef LCD_RX_READBACK_EN
  // Drive status or blank data back while the synced strobe of a read is high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lcd_data_oe  <= 1'b0;
      lcd_data_out <= '0;
    end else begin
      lcd_data_oe <= e_s & rw_s;
      if (e_s && rw_s) lcd_data_out <= rs_s ? 8'h20 : {busy, ac};
      else             lcd_data_out <= '0;
    end
  end
`else
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized + directed bench for lcd_bus_receiver against a transaction-level model of the bus receiver.
module tb_lcd_bus_receiver;

  localparam int L_N   = 5;
  localparam int L_C   = 20;
  localparam int DEPTH = 8;
  localparam int HMAX  = 32768;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] db = 8'h00;
  logic       evt_ready = 1'b1, err_clr = 1'b0;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe, evt_valid, evt_rs, busy;
  logic [7:0] evt_data;
  logic [6:0] evt_addr, ac;
  logic [1:0] err;

  lcd_bus_receiver #(
    .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .BUSY_CYCLES(L_N), .CLR_BUSY_CYCLES(L_C)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .lcd_en(en), .lcd_rs(rs), .lcd_rw(rw),
    .lcd_data_in(db), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rs(evt_rs), .evt_data(evt_data),
    .evt_addr(evt_addr), .ac(ac), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic rs; logic [7:0] db; logic [6:0] addr;} evt_t;

  int   tests = 0, fails = 0;
  int   cyc = 0;
  bit   he[HMAX], hrs[HMAX], hrw[HMAX];
  logic [7:0] hdb[HMAX];

  logic [6:0] m_ac;
  bit         m_id;
  int         m_busy_end;
  logic [1:0] m_err;
  evt_t       mq[$];
  evt_t       log_q[$];
  logic [6:0] p_ac;
  bit         p_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin history as seen by the first synchronizer stage at each rising edge.
  always @(posedge clk) begin
    if (cyc + 1 < HMAX) begin
      he[cyc+1]  <= en;
      hrs[cyc+1] <= rs;
      hrw[cyc+1] <= rw;
      hdb[cyc+1] <= db;
    end
    cyc <= cyc + 1;
  end

  // Model step for the cycle that follows rising edge n; a pin fall at edge f takes effect at edge f+3.
  task automatic model_step(input int n);
    bit         exp_busy, exp_oe, long_b;
    logic [7:0] exp_out;
    logic [1:0] err_n;
    int         f;
    evt_t       e;
    exp_busy = (n < m_busy_end);
    chk("ac", 64'(ac), 64'(m_ac));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("err", 64'(err), 64'(m_err));
    chk("evt_valid", 64'(evt_valid), 64'(mq.size() != 0));
    if (mq.size() != 0 && evt_valid) chk("evt_head", 64'({evt_rs, evt_data, evt_addr}), 64'(mq[0]));
`ifdef LCD_RX_READBACK_EN
    exp_oe  = (n >= 2) && he[n-2] && hrw[n-2];
    exp_out = !exp_oe ? 8'h00 : (hrs[n-2] ? 8'h20 : {p_busy, p_ac});
`else
    exp_oe  = 1'b0;
    exp_out = 8'h00;
`endif
    chk("data_oe", 64'(lcd_data_oe), 64'(exp_oe));
    chk("data_out", 64'(lcd_data_out), 64'(exp_out));
    p_ac   = m_ac;
    p_busy = exp_busy;

    if (mq.size() != 0 && evt_ready) log_q.push_back(mq.pop_front());
    err_n = err_clr ? 2'b00 : m_err;
    if (n >= 3 && he[n-3] && !he[n-2]) begin
      f = n - 2;
      if (!hrw[f]) begin
        if (exp_busy) err_n[1] = 1'b1;
        e = '{rs: hrs[f], db: hdb[f], addr: m_ac};
        if (mq.size() < DEPTH) mq.push_back(e);
        else err_n[0] = 1'b1;
        long_b = 1'b0;
        if (hrs[f])               m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
        else if (hdb[f] >= 8'h80) m_ac = hdb[f][6:0];
        else if (hdb[f] >= 8'h08) m_ac = m_ac;
        else if (hdb[f] >= 8'h04) m_id = hdb[f][1];
        else if (hdb[f] >= 8'h02) begin m_ac = 7'd0; long_b = 1'b1; end
        else if (hdb[f] == 8'h01) begin m_ac = 7'd0; m_id = 1'b1; long_b = 1'b1; end
        m_busy_end = n + 1 + (long_b ? L_C : L_N);
      end
`ifdef LCD_RX_READBACK_EN
      else if (hrs[f]) m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
`endif
    end
    m_err = err_n;
  endtask

  // Compare process: sampled mid-low-phase, after stimulus has settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("reset_bus", 64'({lcd_data_out, lcd_data_oe}), 64'(0));
        chk("reset_state", 64'({evt_valid, evt_rs, evt_data, evt_addr, ac, busy, err}), 64'(0));
        m_ac = 7'd0; m_id = 1'b1; m_busy_end = 0; m_err = 2'b00;
        mq.delete(); p_ac = 7'd0; p_busy = 1'b0;
      end else begin
        model_step(cyc);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic bus_xfer(input bit r_s, input bit r_w, input logic [7:0] d, input int hold, input int gap);
    tick(1);
    rs = r_s; rw = r_w; db = d; en = 1'b1;
    tick(hold);
    en = 1'b0;
    tick(gap);
  endtask

  initial begin
    bit         seen;
    bit         r_s, r_w;
    logic [7:0] d;
    int         hold;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      en = ~en; rs = 1'($urandom); db = 8'($urandom);
      tick(1);
    end
    en = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_ac", 64'(ac), 64'(0));
    chk("post_reset_valid", 64'(evt_valid), 64'(0));

    // Set address then a data write.
    log_q.delete();
    bus_xfer(0, 0, 8'hC0, 4, 10);
    bus_xfer(1, 0, 8'h41, 4, 10);
    chk("ac_after_41", 64'(ac), 64'h41);
    chk("err_clean", 64'(err), 64'h0);
    chk("log_size", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("evt0", 64'(log_q[0]), 64'({1'b0, 8'hC0, 7'h00}));
      chk("evt1", 64'(log_q[1]), 64'({1'b1, 8'h41, 7'h40}));
    end

    // Wrap in both directions.
    bus_xfer(0, 0, 8'h80, 4, 10);
    bus_xfer(0, 0, 8'h04, 4, 10);
    bus_xfer(1, 0, 8'h33, 4, 10);
    chk("wrap_down", 64'(ac), 64'h7F);
    bus_xfer(0, 0, 8'h06, 4, 10);
    bus_xfer(1, 0, 8'h34, 4, 10);
    chk("wrap_up", 64'(ac), 64'h00);

    // Clear, then a data write inside the long busy window.
    bus_xfer(0, 0, 8'h01, 4, 4);
    bus_xfer(1, 0, 8'h55, 4, 2);
    tick(4);
    chk("busy_after_data", 64'(busy), 64'd1);
    chk("err_wr_busy", 64'(err), 64'b10);
    chk("ac_after_clr", 64'(ac), 64'h01);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", 64'(err), 64'b00);
    tick(5);
    chk("busy_expired", 64'(busy), 64'd0);

    // Overflow: nine pushes into eight slots with the consumer stalled.
    tick(30);
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_xfer(1, 0, 8'(8'h10 + i), 3, 6);
    tick(10);
    chk("err_overflow", 64'(err), 64'b01);
    log_q.delete();
    evt_ready = 1'b1;
    tick(20);
    chk("drain_size", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("drain_data", 64'(log_q[i].db), 64'(8'(8'h10 + i)));
    chk("drain_empty", 64'(evt_valid), 64'd0);

    // Status readback while busy.
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    bus_xfer(0, 0, 8'h85, 4, 0);
    tick(1);
    rs = 1'b0; rw = 1'b1; en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (lcd_data_oe && lcd_data_out == 8'h85) seen = 1'b1;
    end
    en = 1'b0;
    tick(8);
`ifdef LCD_RX_READBACK_EN
    chk("readback_85", 64'(seen), 64'd1);
`else
    chk("readback_off", 64'(seen), 64'd0);
`endif
    chk("ac_after_read", 64'(ac), 64'h05);
    rw = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      err_clr   = ($urandom_range(0, 7) == 0);
      evt_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      err_clr = 1'b0;
      r_w = ($urandom_range(0, 3) == 0);
      r_s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: d = 8'h80 | 8'($urandom_range(0, 127));
        1: d = 8'h04 | 8'($urandom_range(0, 3));
        2: d = 8'($urandom_range(0, 3));
        default: d = 8'($urandom);
      endcase
      hold = r_w ? $urandom_range(5, 8) : $urandom_range(1, 6);
      bus_xfer(r_s, r_w, d, hold, $urandom_range(0, 25));
    end
    evt_ready = 1'b1;
    tick(40);
    chk("final_empty", 64'(evt_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
